// File: rtl/tx_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tx_arbiter
//
// Frame-granular arbiter sharing the single tx_sm FIFO-read interface between
// requester 0 (rx loopback path) and requester 1 (host frame source). The
// winner owns the interface until the last byte of its frame is read, then
// the grant drops for GAP_CYCLES idle cycles before the next arbitration. A
// byte-count watchdog aborts any grant that reaches MAX_FRAME_BYTES reads
// without seeing an end-of-frame byte.
//
// Build option:
//   TX_ARB_FIXED_PRIORITY_EN  defined   -> requester 0 always wins a tie
//                             undefined -> round-robin on ties (default)
//
// Parameters:
//   GAP_CYCLES       idle cycles between release and next arbitration (>=0)
//   MAX_FRAME_BYTES  watchdog limit on reads within one grant (>=2)
//   COUNT_WIDTH      width of the per-requester completed-frame counters
//
// Ports:
//   clock, reset                  clock, async active-high reset
//   reqN_data/start/end           head byte and frame flags of requester N
//   reqN_available                requester N has a complete frame queued
//   reqN_read                     pop strobe back to requester N
//   fifo_data/_start/_end         muxed head byte and flags towards tx_sm
//   fifo_data_available           granted requester's availability
//   fifo_data_read                pop strobe from tx_sm
//   grant                         one-hot owner, 00 = none
//   overrun                       one-cycle pulse on watchdog abort
//   frames0/frames1               completed frames per requester (wrapping)
// -----------------------------------------------------------------------------
module tx_arbiter #(
  parameter int GAP_CYCLES      = 2,
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             req0_data,
  input  logic                   req0_start,
  input  logic                   req0_end,
  input  logic                   req0_available,
  output logic                   req0_read,
  input  logic [7:0]             req1_data,
  input  logic                   req1_start,
  input  logic                   req1_end,
  input  logic                   req1_available,
  output logic                   req1_read,
  output logic [7:0]             fifo_data,
  output logic                   fifo_data_start,
  output logic                   fifo_data_end,
  output logic                   fifo_data_available,
  input  logic                   fifo_data_read,
  output logic [1:0]             grant,
  output logic                   overrun,
  output logic [COUNT_WIDTH-1:0] frames0,
  output logic [COUNT_WIDTH-1:0] frames1
);

  localparam int BYTE_W = $clog2(MAX_FRAME_BYTES + 1);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // Count value at which one more read would hit the watchdog limit.
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(MAX_FRAME_BYTES - 1);
  // Gap counter value of the final gap cycle (unused when GAP_CYCLES is 0).
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // With no gap configured a release goes straight back to arbitration.
  localparam state_t REL_STATE = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  state_t                   state_r;
  state_t                   next_state_s;
  logic [1:0]               grant_r;
  logic [1:0]               win_s;
  logic                     normal_end_s;
  logic                     abort_s;
  logic [BYTE_W-1:0]        byte_cnt_r;
  logic [GAP_W-1:0]         gap_cnt_r;
  logic                     overrun_r;
  logic [COUNT_WIDTH-1:0]   frames0_r;
  logic [COUNT_WIDTH-1:0]   frames1_r;

`ifdef TX_ARB_FIXED_PRIORITY_EN
  // Fixed priority needs no memory of the previous owner.
`else
  logic                     last_served_r;

  // Remember which requester owned the most recently released grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_served_r <= 1'b1;
    end else if (normal_end_s || abort_s) begin
      last_served_r <= grant_r[1];
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: arbitration, frame end, watchdog abort and gap timing.
  always_comb begin
    next_state_s = state_r;
    win_s        = 2'b00;
    normal_end_s = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req0_available && req1_available) begin
`ifdef TX_ARB_FIXED_PRIORITY_EN
          win_s = 2'b01;
`else
          // Tie: serve whichever requester did not own the previous grant.
          win_s = last_served_r ? 2'b01 : 2'b10;
`endif
          next_state_s = ST_GRANT;
        end else if (req0_available) begin
          win_s        = 2'b01;
          next_state_s = ST_GRANT;
        end else if (req1_available) begin
          win_s        = 2'b10;
          next_state_s = ST_GRANT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (fifo_data_read && fifo_data_end) begin
          normal_end_s = 1'b1;
          next_state_s = REL_STATE;
        end else if (fifo_data_read && (byte_cnt_r == BYTE_LAST)) begin
          // This read would reach the limit with no end flag in sight.
          abort_s      = 1'b1;
          next_state_s = REL_STATE;
        end else begin
          next_state_s = ST_GRANT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Output mux: the granted requester drives tx_sm, reads are routed back only to it.
  always_comb begin
    fifo_data           = 8'h00;
    fifo_data_start     = 1'b0;
    fifo_data_end       = 1'b0;
    fifo_data_available = 1'b0;
    req0_read           = 1'b0;
    req1_read           = 1'b0;
    grant               = grant_r;
    overrun             = overrun_r;
    frames0             = frames0_r;
    frames1             = frames1_r;
    case (grant_r)
      2'b01: begin
        fifo_data           = req0_data;
        fifo_data_start     = req0_start;
        fifo_data_end       = req0_end;
        fifo_data_available = req0_available;
        req0_read           = fifo_data_read;
      end
      2'b10: begin
        fifo_data           = req1_data;
        fifo_data_start     = req1_start;
        fifo_data_end       = req1_end;
        fifo_data_available = req1_available;
        req1_read           = fifo_data_read;
      end
      default: begin
        fifo_data = 8'h00;
      end
    endcase
  end

  // Datapath registers: grant owner, byte and gap counters, overrun pulse, frame counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_r    <= 2'b00;
      byte_cnt_r <= '0;
      gap_cnt_r  <= '0;
      overrun_r  <= 1'b0;
      frames0_r  <= '0;
      frames1_r  <= '0;
    end else begin
      overrun_r <= abort_s;

      case (state_r)
        ST_IDLE:  grant_r <= win_s;
        ST_GRANT: grant_r <= (normal_end_s || abort_s) ? 2'b00 : grant_r;
        default:  grant_r <= 2'b00;
      endcase

      if (state_r == ST_IDLE) begin
        byte_cnt_r <= '0;
      end else if ((state_r == ST_GRANT) && fifo_data_read) begin
        byte_cnt_r <= byte_cnt_r + BYTE_W'(1);
      end

      if (state_r == ST_GAP) begin
        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
      end else begin
        gap_cnt_r <= '0;
      end

      // Only properly terminated frames are counted; counters wrap naturally.
      if (normal_end_s && grant_r[0]) begin
        frames0_r <= frames0_r + COUNT_WIDTH'(1);
      end
      if (normal_end_s && grant_r[1]) begin
        frames1_r <= frames1_r + COUNT_WIDTH'(1);
      end
    end
  end

endmodule
